// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: result-select encoding, register-file geometry
// and the commit rule used by the writeback stage.
package pipeline_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_A0 = 5'd10;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'b00,
    RESULT_MEM = 2'b01,
    RESULT_PC4 = 2'b10
  } result_src_t;

  // A write to x0 is architecturally a no-op, so it never counts as a commit.
  function automatic logic is_commit(input logic                  reg_write,
                                     input logic [REG_ADDR_W-1:0] rd);
    return reg_write && (rd != '0);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 32 x WIDTH, x0 reads as zero, two combinational
// read ports, one write port, asynchronous active-high reset.
module reg_file
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]      rdata1,
  output logic [WIDTH-1:0]      rdata2,
  output logic [WIDTH-1:0]      a0
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  // NOTE: this storage is reset on purpose -- the whole file must read zero
  // immediately on reset, so it maps to flops rather than a RAM macro.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
  assign a0     = regs[REG_A0];

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: result select, register-file commit with same-cycle read
// bypass for decode, a0 observation port and committed-write counter.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcW,
  input  logic [WIDTH-1:0]      ALUResultW,
  input  logic [WIDTH-1:0]      ReadDataW,
  input  logic [WIDTH-1:0]      PCPlus4W,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [REG_ADDR_W-1:0] A1D,
  input  logic [REG_ADDR_W-1:0] A2D,
  output logic [WIDTH-1:0]      RD1D,
  output logic [WIDTH-1:0]      RD2D,
  output logic [WIDTH-1:0]      ResultW,
  output logic [WIDTH-1:0]      a0,
  output logic [WIDTH-1:0]      WriteCount
);

  logic             commit;
  logic [WIDTH-1:0] rf_rd1;
  logic [WIDTH-1:0] rf_rd2;

  // NOTE: the default is assigned before the case so no path leaves result
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ResultW = ALUResultW;
    case (result_src_t'(ResultSrcW))
      RESULT_MEM: ResultW = ReadDataW;
      RESULT_PC4: ResultW = PCPlus4W;
      default:    ResultW = ALUResultW;  // reserved 2'b11 behaves as ALU
    endcase
  end

  assign commit = is_commit(RegWriteW, RdW);

  reg_file #(
    .WIDTH(WIDTH)
  ) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .we    (commit),
    .waddr (RdW),
    .wdata (ResultW),
    .raddr1(A1D),
    .raddr2(A2D),
    .rdata1(rf_rd1),
    .rdata2(rf_rd2),
    .a0    (a0)
  );

  // Bypass stands in for a falling-edge write: decode sees the WB value now.
  // commit already excludes x0, so a matching address is never zero here.
  assign RD1D = (commit && (A1D == RdW)) ? ResultW : rf_rd1;
  assign RD2D = (commit && (A2D == RdW)) ? ResultW : rf_rd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WriteCount <= '0;
    end else if (commit) begin
      WriteCount <= WriteCount + WIDTH'(1);
    end
  end

endmodule
